tile_map_ctrl: RTL and testbench
================================

// Module: tile_map_ctrl
// PURPOSE
//  Tile-map store and arbiter directly downstream of the game-logic stage.
//  Holds one 8-bit sprite code per tile of a COLS x ROWS map in a single-port RAM.
//  Serves three clients: video fetches (highest priority), game writes/reads (update/get),
//  and a serial dump of the whole map (start).
// PARAMETERS
//  COLS   40  map width in tiles (addr = row*COLS + col)
//  ROWS   30  map height in tiles
//  AW     11  RAM address width; must satisfy 2**AW >= COLS*ROWS
// PORTS
//  px_clk       in   1  pixel clock; single clock domain
//  rst          in   1  reset, asynchronous, active-high
//  vid_req      in   1  video tile fetch request, sampled every cycle
//  vid_col      in   6  video tile column
//  vid_row      in   6  video tile row
//  vid_tile     out  8  fetched sprite code
//  vid_valid    out  1  vid_tile valid, exactly 1 cycle after vid_req
//  update       in   1  game write request (level; acted on at rising edge)
//  get          in   1  game read request (level; acted on at rising edge)
//  posx         in   6  game tile column
//  posy         in   6  game tile row
//  sprite       in   8  sprite code to write
//  read_sprite  out  8  result of last get; held until next result
//  ready        out  1  1-cycle pulse, read_sprite updated this cycle
//  start        in   1  dump request (acted on at rising edge)
//  serial_out   out  8  dump byte to UART, stable while serial_send high
//  serial_send  out  1  1-cycle pulse: UART, transmit serial_out
//  serial_done  in   1  1-cycle pulse from UART: byte sent
//  dump_busy    out  1  high from accepted start until last byte done
// BEHAVIOUR
//  Reset: all outputs 0; edge detectors, pending flags, dump FSM cleared. RAM not cleared.
//  Address: row*COLS+col via shifts/adds ((row<<5)+(row<<3)+col for 40); AW bits.
//  Out of range (col>=COLS or row>=ROWS): write dropped; read returns 8'h00
//    (video and get alike). No aliasing into another tile.
//  Edge detect: update/get/start registered; request = in & ~in_q.
//  Write edge latches {posx,posy,sprite} and sets wr_pend. A new edge while pending
//    overwrites the latch (last wins, one write).
//  Get edge latches {posx,posy} and sets rd_pend. Same rule: last wins.
//  RAM slot arbitration, one access per cycle: vid_req > wr_pend > rd_pend > dump read.
//  Video: never stalled; vid_valid=1 and vid_tile=RAM[addr] on the next cycle.
//  Write: performed in the first cycle with vid_req=0; wr_pend clears that cycle.
//  Get: serviced in the first free cycle after any pending write, so a get issued with
//    or after an update to the same tile returns the new code. Next cycle ready=1 and
//    read_sprite=data. Latency 2 cycles minimum from get edge, unbounded under video load.
//  Dump FSM: D_IDLE -> (start edge) D_RD -> D_SEND -> D_WAIT -> D_RD | D_IDLE.
//    D_IDLE: dump_busy=0; idx=0.
//    D_RD: waits for a free RAM slot, reads RAM[idx].
//    D_SEND: serial_out=data; serial_send pulses 1 cycle.
//    D_WAIT: holds serial_out until serial_done. idx==COLS*ROWS-1 -> D_IDLE, else idx+1 -> D_RD.
//    Exactly COLS*ROWS bytes per dump, row-major from (0,0).
//  start edge while dump_busy: ignored. Game writes during a dump are allowed;
//    bytes not yet read show the new value.
//  serial_done outside D_WAIT: ignored.
//  Reset mid-dump or mid-request: FSM to D_IDLE, pending requests discarded, no further
//    serial_send; RAM keeps its contents.
// TESTING
//  update edge (posx=6,posy=6,sprite=8'h42), vid_req=0 -> RAM[246]=8'h42; get same tile ->
//    ready pulse 2 cycles after edge, read_sprite=8'h42.
//  vid_req held high 10 cycles plus update edge -> vid_valid every cycle, write waits; then
//    write lands on first idle cycle; vid fetch of (6,6) next frame returns new code.
//  update and get edges same cycle, same tile (9,3,8'h11) -> read_sprite=8'h11 (write first).
//  Out-of-range: update at (40,0) and (0,30) -> no RAM change; get (40,0) -> read_sprite=8'h00.
//  start edge, UART model returns serial_done 5 cycles after each send -> 1200 sends in
//    row-major order, dump_busy falls after done #1200; second start mid-dump ignored.
//  rst asserted after byte 17 of a dump -> serial_send stops, dump_busy=0 asynchronously;
//    new start after release restarts at idx 0.

Source files
------------

// File: rtl/tile_map_ctrl.sv
// Tile-map store with a single-port RAM shared by video fetches, game update/get
// requests and a serial dump of the whole map, arbitrated one access per cycle.
module tile_map_ctrl #(
  parameter int COLS = 40,
  parameter int ROWS = 30,
  parameter int AW   = 11
) (
  input  logic       px_clk,
  input  logic       rst,
  input  logic       vid_req,
  input  logic [5:0] vid_col,
  input  logic [5:0] vid_row,
  output logic [7:0] vid_tile,
  output logic       vid_valid,
  input  logic       update,
  input  logic       get,
  input  logic [5:0] posx,
  input  logic [5:0] posy,
  input  logic [7:0] sprite,
  output logic [7:0] read_sprite,
  output logic       ready,
  input  logic       start,
  output logic [7:0] serial_out,
  output logic       serial_send,
  input  logic       serial_done,
  output logic       dump_busy
);

  localparam int            TILES    = COLS * ROWS;
  localparam logic [AW-1:0] LAST_IDX = AW'(TILES - 1);

  typedef enum logic [1:0] {D_IDLE, D_RD, D_SEND, D_WAIT} dump_state_e;

  function automatic logic in_map(input logic [5:0] col, input logic [5:0] row);
    return (32'(col) < COLS) && (32'(row) < ROWS);
  endfunction

  function automatic logic [AW-1:0] tile_addr(input logic [5:0] col, input logic [5:0] row);
    return AW'(32'(row) * COLS + 32'(col));
  endfunction

  logic [7:0] mem [0:(1<<AW)-1];

  logic          update_q, get_q, start_q;
  logic          wr_pend_q, rd_pend_q;
  logic [5:0]    wr_col_q, wr_row_q, rd_col_q, rd_row_q;
  logic [7:0]    wr_data_q;
  dump_state_e   dump_q;
  logic [AW-1:0] idx_q;

  logic [7:0] vid_tile_q, read_sprite_q, serial_out_q;
  logic       vid_valid_q, ready_q, serial_send_q, dump_busy_q;

  logic          update_edge, get_edge, start_edge;
  logic          gnt_wr, gnt_rd, gnt_dump, ram_we;
  logic [AW-1:0] ram_addr;
  logic [7:0]    ram_rdata;

  assign update_edge = update & ~update_q;
  assign get_edge    = get & ~get_q;
  assign start_edge  = start & ~start_q;

  // Fixed-priority slot: video, then pending write, then pending get, then dump.
  // NOTE: every signal gets a default before the if-chain so no latch is inferred.
  always_comb begin
    gnt_wr   = 1'b0;
    gnt_rd   = 1'b0;
    gnt_dump = 1'b0;
    ram_addr = '0;
    if (vid_req) begin
      ram_addr = tile_addr(vid_col, vid_row);
    end else if (wr_pend_q) begin
      gnt_wr   = 1'b1;
      ram_addr = tile_addr(wr_col_q, wr_row_q);
    end else if (rd_pend_q) begin
      gnt_rd   = 1'b1;
      ram_addr = tile_addr(rd_col_q, rd_row_q);
    end else if (dump_q == D_RD) begin
      gnt_dump = 1'b1;
      ram_addr = idx_q;
    end
  end

  assign ram_we    = gnt_wr & in_map(wr_col_q, wr_row_q);
  assign ram_rdata = mem[ram_addr];

  // NOTE: the tile array has no reset so it maps onto RAM; contents survive rst.
  always_ff @(posedge px_clk) begin
    if (ram_we) mem[ram_addr] <= wr_data_q;
  end

  always_ff @(posedge px_clk or posedge rst) begin
    if (rst) begin
      update_q      <= 1'b0;
      get_q         <= 1'b0;
      start_q       <= 1'b0;
      wr_pend_q     <= 1'b0;
      rd_pend_q     <= 1'b0;
      wr_col_q      <= '0;
      wr_row_q      <= '0;
      wr_data_q     <= '0;
      rd_col_q      <= '0;
      rd_row_q      <= '0;
      dump_q        <= D_IDLE;
      idx_q         <= '0;
      vid_tile_q    <= '0;
      vid_valid_q   <= 1'b0;
      read_sprite_q <= '0;
      ready_q       <= 1'b0;
      serial_out_q  <= '0;
      serial_send_q <= 1'b0;
      dump_busy_q   <= 1'b0;
    end else begin
      update_q <= update;
      get_q    <= get;
      start_q  <= start;

      vid_valid_q <= vid_req;
      if (vid_req) vid_tile_q <= in_map(vid_col, vid_row) ? ram_rdata : 8'h00;

      ready_q <= gnt_rd;
      if (gnt_rd) read_sprite_q <= in_map(rd_col_q, rd_row_q) ? ram_rdata : 8'h00;

      // NOTE: a fresh edge in the same cycle as service re-arms the flag, because
      // the later non-blocking assignment to the same register wins.
      if (gnt_wr) wr_pend_q <= 1'b0;
      if (update_edge) begin
        wr_pend_q <= 1'b1;
        wr_col_q  <= posx;
        wr_row_q  <= posy;
        wr_data_q <= sprite;
      end
      if (gnt_rd) rd_pend_q <= 1'b0;
      if (get_edge) begin
        rd_pend_q <= 1'b1;
        rd_col_q  <= posx;
        rd_row_q  <= posy;
      end

      serial_send_q <= 1'b0;
      case (dump_q)
        D_IDLE: begin
          idx_q <= '0;
          if (start_edge) begin
            dump_q      <= D_RD;
            dump_busy_q <= 1'b1;
          end
        end
        D_RD: begin
          if (gnt_dump) begin
            serial_out_q  <= ram_rdata;
            serial_send_q <= 1'b1;
            dump_q        <= D_SEND;
          end
        end
        D_SEND: dump_q <= D_WAIT;
        D_WAIT: begin
          if (serial_done) begin
            if (idx_q == LAST_IDX) begin
              dump_q      <= D_IDLE;
              dump_busy_q <= 1'b0;
              idx_q       <= '0;
            end else begin
              idx_q  <= idx_q + AW'(1);
              dump_q <= D_RD;
            end
          end
        end
        default: dump_q <= D_IDLE;
      endcase
    end
  end

  assign vid_tile    = vid_tile_q;
  assign vid_valid   = vid_valid_q;
  assign read_sprite = read_sprite_q;
  assign ready       = ready_q;
  assign serial_out  = serial_out_q;
  assign serial_send = serial_send_q;
  assign dump_busy   = dump_busy_q;

endmodule

// File: tb/tb_tile_map_ctrl.sv
// Randomized bench for tile_map_ctrl: a tile-array model with pending-write and
// pending-get bookkeeping predicts every video fetch, get result and dump byte.
module tb_tile_map_ctrl;

  localparam int COLS  = 40;
  localparam int ROWS  = 30;
  localparam int TILES = COLS * ROWS;

  logic       px_clk = 1'b0;
  logic       rst;
  logic       vid_req, update, get, start, serial_done;
  logic [5:0] vid_col, vid_row, posx, posy;
  logic [7:0] sprite;
  logic [7:0] vid_tile, read_sprite, serial_out;
  logic       vid_valid, ready, serial_send, dump_busy;

  tile_map_ctrl #(.COLS(COLS), .ROWS(ROWS), .AW(11)) dut (
    .px_clk(px_clk), .rst(rst),
    .vid_req(vid_req), .vid_col(vid_col), .vid_row(vid_row),
    .vid_tile(vid_tile), .vid_valid(vid_valid),
    .update(update), .get(get), .posx(posx), .posy(posy), .sprite(sprite),
    .read_sprite(read_sprite), .ready(ready),
    .start(start), .serial_out(serial_out), .serial_send(serial_send),
    .serial_done(serial_done), .dump_busy(dump_busy)
  );

  always #5 px_clk = ~px_clk;

  int checks = 0;
  int passed = 0;

  logic [7:0] model_mem [TILES];
  bit         m_wr_pend, get_out, m_busy, uart_active;
  int         m_wr_col, m_wr_row, get_col, get_row, get_lat, last_get_lat;
  logic [7:0] m_wr_data, exp_vid, last_sent;
  bit         exp_vid_pend, upd_prev, get_prev, start_prev;
  int         m_idx, uart_cnt, sends;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  function automatic logic [7:0] peek(input int col, input int row);
    if (col < COLS && row < ROWS) return model_mem[row * COLS + col];
    return 8'h00;
  endfunction

  function automatic logic [5:0] rc(input int lim);
    if ($urandom_range(0, 9) == 0) return 6'($urandom_range(0, 63));
    return 6'($urandom_range(0, lim - 1));
  endfunction

  task automatic model_reset();
    m_wr_pend = 0; get_out = 0; m_busy = 0; uart_active = 0; m_idx = 0;
    upd_prev = 0; get_prev = 0; start_prev = 0; exp_vid_pend = 0;
    vid_req = 0; update = 0; get = 0; start = 0; serial_done = 0;
  endtask

  // Apply this cycle's effects to the model, clock once, then check outputs.
  task automatic cycle();
    if (serial_done && m_busy) begin
      m_idx++;
      if (m_idx == TILES) m_busy = 0;
    end
    exp_vid_pend = vid_req;
    exp_vid      = peek(int'(vid_col), int'(vid_row));
    if (!vid_req && m_wr_pend) begin
      if (m_wr_col < COLS && m_wr_row < ROWS) model_mem[m_wr_row * COLS + m_wr_col] = m_wr_data;
      m_wr_pend = 0;
    end
    if (update && !upd_prev) begin
      m_wr_pend = 1; m_wr_col = int'(posx); m_wr_row = int'(posy); m_wr_data = sprite;
    end
    if (get && !get_prev) begin
      get_out = 1; get_col = int'(posx); get_row = int'(posy); get_lat = 0;
    end
    if (start && !start_prev && !m_busy) begin
      m_busy = 1; m_idx = 0;
    end
    upd_prev = update; get_prev = get; start_prev = start;

    @(posedge px_clk); #1;

    check("vid_valid", vid_valid, exp_vid_pend);
    if (exp_vid_pend) check("vid_tile", vid_tile, exp_vid);
    check("dump_busy", dump_busy, m_busy);
    if (get_out) get_lat++;
    if (ready) begin
      check("ready_expected", get_out, 1);
      if (get_out) check("read_sprite", read_sprite, peek(get_col, get_row));
      last_get_lat = get_lat;
      get_out = 0;
    end else if (get_out && get_lat > 500) begin
      check("get_timeout_ready", ready, 1);
      get_out = 0;
    end
    if (serial_send) begin
      check("send_uart_idle", uart_active, 0);
      check("send_in_dump", m_busy, 1);
      if (m_busy && m_idx < TILES) check("serial_out", serial_out, model_mem[m_idx]);
      last_sent = serial_out;
      sends++;
      uart_active = 1; uart_cnt = 5; serial_done = 0;
    end else if (uart_active) begin
      uart_cnt--;
      if (uart_cnt == 0) begin
        check("serial_hold", serial_out, last_sent);
        serial_done = 1; uart_active = 0;
      end else serial_done = 0;
    end else serial_done = 0;
  endtask

  task automatic wait_get();
    for (int i = 0; i < 600 && get_out; i++) cycle();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [7:0] alias_val;
    bit         second_start;
    model_reset();
    vid_col = 0; vid_row = 0; posx = 0; posy = 0; sprite = 0;
    sends = 0; last_get_lat = -1; last_sent = 0;
    rst = 1'b1;
    repeat (3) @(posedge px_clk);
    #1;
    check("rst_vid_tile", vid_tile, 0);
    check("rst_vid_valid", vid_valid, 0);
    check("rst_read_sprite", read_sprite, 0);
    check("rst_ready", ready, 0);
    check("rst_serial_out", serial_out, 0);
    check("rst_serial_send", serial_send, 0);
    check("rst_dump_busy", dump_busy, 0);
    rst = 1'b0;

    // Fill every tile so later reads have defined contents.
    for (int a = 0; a < TILES; a++) begin
      posx = 6'(a % COLS); posy = 6'(a / COLS); sprite = 8'($urandom);
      update = 1; cycle();
      update = 0; cycle();
    end
    cycle();

    // Write then get the same tile with an idle RAM.
    posx = 6; posy = 6; sprite = 8'h42;
    update = 1; cycle();
    update = 0; get = 1; cycle();
    get = 0; cycle(); cycle();
    check("get_latency", last_get_lat, 2);
    check("get_6_6", read_sprite, 8'h42);

    // Write waits behind continuous video fetches of the same tile.
    posx = 6; posy = 6; sprite = 8'h5A;
    vid_req = 1; vid_col = 6; vid_row = 6;
    update = 1; cycle();
    update = 0;
    repeat (9) cycle();
    check("vid_old_code", vid_tile, 8'h42);
    vid_req = 0; cycle();
    vid_req = 1; cycle();
    check("vid_new_code", vid_tile, 8'h5A);
    vid_req = 0; cycle();

    // Update and get on the same edge: the write goes first.
    posx = 9; posy = 3; sprite = 8'h11;
    update = 1; get = 1; cycle();
    update = 0; get = 0; wait_get();
    check("rw_same_cycle", read_sprite, 8'h11);

    // Out-of-range writes are dropped and never alias onto real tiles.
    alias_val = peek(0, 1);
    posx = 40; posy = 0; sprite = ~alias_val;
    update = 1; cycle(); update = 0; cycle(); cycle();
    posx = 0; posy = 30;
    update = 1; cycle(); update = 0; cycle(); cycle();
    posx = 40; posy = 0;
    get = 1; cycle(); get = 0; wait_get();
    check("oor_get", read_sprite, 8'h00);
    posx = 0; posy = 1;
    get = 1; cycle(); get = 0; wait_get();
    check("no_alias", read_sprite, alias_val);

    // Random mix of video load, updates and gets.
    for (int i = 0; i < 3000; i++) begin
      vid_req = ($urandom_range(0, 99) < 50);
      vid_col = rc(COLS); vid_row = rc(ROWS);
      posx = rc(COLS); posy = rc(ROWS); sprite = 8'($urandom);
      update = ($urandom_range(0, 99) < 15);
      get = get_out ? 1'b0 : ($urandom_range(0, 99) < 20);
      cycle();
    end
    vid_req = 0; update = 0; get = 0;
    for (int i = 0; i < 600 && (get_out || m_wr_pend); i++) cycle();
    cycle();

    // Dump interrupted by reset after byte 17.
    sends = 0;
    start = 1; cycle(); start = 0;
    for (int i = 0; i < 2000 && sends < 17; i++) begin
      vid_req = ($urandom_range(0, 99) < 30);
      vid_col = rc(COLS); vid_row = rc(ROWS);
      cycle();
    end
    #2 rst = 1'b1;
    #1;
    check("rst_mid_busy", dump_busy, 0);
    check("rst_mid_send", serial_send, 0);
    model_reset();
    repeat (3) cycle();
    rst = 1'b0;
    repeat (10) cycle();
    check("rst_no_more_sends", sends, 17);

    // Full dump under video load with game writes and a second start mid-dump.
    sends = 0; second_start = 0;
    start = 1; cycle(); start = 0;
    for (int i = 0; i < 40000 && m_busy; i++) begin
      vid_req = ($urandom_range(0, 99) < 30);
      vid_col = rc(COLS); vid_row = rc(ROWS);
      posx = rc(COLS); posy = rc(ROWS); sprite = 8'($urandom);
      update = ($urandom_range(0, 99) < 3);
      get = get_out ? 1'b0 : ($urandom_range(0, 99) < 3);
      start = 0;
      if (sends == 100 && !second_start) begin
        start = 1; second_start = 1;
      end
      cycle();
    end
    vid_req = 0; update = 0; get = 0; start = 0;
    check("dump_bytes", sends, TILES);
    repeat (20) cycle();
    check("dump_bytes_final", sends, TILES);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
